// File: rtl/uart_out_line_buffer.sv
// Line-atomic console buffer: captures UART bytes, strips CR, releases whole lines or a full-buffer flush.
// Optional statistics counters are enabled by defining UART_OUT_STATS_EN.
module uart_out_line_buffer #(
  parameter int DEPTH = 64
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [7:0]               in_ch,
  output logic                     out_valid,
  output logic [7:0]               out_ch,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
`ifdef UART_OUT_STATS_EN
  ,
  output logic [31:0]              stat_chars,
  output logic [31:0]              stat_drops,
  output logic [31:0]              stat_lines
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE     = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {IDLE, LINE, FLUSH} state_t;

  state_t        state, next_state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   lines_stored;
  logic [AW:0]   flush_rem;
  logic [7:0]    head;
  logic          is_cr, full, push, drop, pop, line_done;

  // Fullness is judged on the start-of-cycle count, so a same-cycle pop never frees a slot.
  assign head      = mem[rd_ptr];
  assign is_cr     = (in_ch == 8'h0d);
  assign full      = (count == FULL);
  assign push      = in_valid && !is_cr && !full;
  assign drop      = in_valid && !is_cr && full;
  assign pop       = out_valid && out_ready;
  assign line_done = pop && out_last && (state == LINE);

  always_comb begin
    next_state = state;
    out_valid  = 1'b0;
    out_ch     = 8'h00;
    out_last   = 1'b0;
    case (state)
      IDLE: begin
        if (lines_stored != '0)
          next_state = LINE;
        else if (full)
          next_state = FLUSH;
      end
      LINE: begin
        out_valid = 1'b1;
        out_ch    = head;
        out_last  = (head == 8'h0a);
        if (out_ready && out_last)
          next_state = IDLE;
      end
      FLUSH: begin
        out_valid = 1'b1;
        out_ch    = head;
        out_last  = (flush_rem == ONE);
        if (out_ready && out_last)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      flush_rem <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == FLUSH)
        flush_rem <= FULL;
      else if (state == FLUSH && pop)
        flush_rem <= flush_rem - ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= in_ch;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      lines_stored <= '0;
      overflow     <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      case ({push && (in_ch == 8'h0a), line_done})
        2'b10:   lines_stored <= lines_stored + ONE;
        2'b01:   lines_stored <= lines_stored - ONE;
        default: lines_stored <= lines_stored;
      endcase
      if (drop)
        overflow <= 1'b1;
    end
  end

`ifdef UART_OUT_STATS_EN
  // Saturating event counters; they hold at all-ones rather than wrapping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_chars <= '0;
      stat_drops <= '0;
      stat_lines <= '0;
    end else begin
      if (push && stat_chars != 32'hffffffff)
        stat_chars <= stat_chars + 32'd1;
      if (drop && stat_drops != 32'hffffffff)
        stat_drops <= stat_drops + 32'd1;
      if (pop && out_last && stat_lines != 32'hffffffff)
        stat_lines <= stat_lines + 32'd1;
    end
  end
`endif

endmodule
